// File: rtl/clk_period_meter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clk_period_meter_pkg
// Description : Shared constants and state encoding for the period meter.
//               Provides the default measurement width, the default stall
//               timeout and the three-state FSM encoding used by
//               clk_period_meter.
// Revision    : 1.0 - initial release
// ============================================================================
package clk_period_meter_pkg;

  // Defaults for the top-level parameters.
  localparam int c_default_cnt_width = 16;
  localparam int c_default_timeout   = 65535;

  // Meter FSM encoding.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MEAS_HIGH = 2'd1,
    MEAS_LOW  = 2'd2
  } meter_state_e;

endpackage : clk_period_meter_pkg
`default_nettype wire

// File: rtl/clk_period_meter_sync_edge_detect.sv
`default_nettype none
// ============================================================================
// Module      : sync_edge_detect
// Description : Brings an asynchronous input into the clk domain through a
//               SYNC_STAGES-flop synchronizer and produces single-cycle
//               rise/fall strobes from the synchronized level. Usable for any
//               slow asynchronous input (dividers, buttons, UART rx).
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters  : SYNC_STAGES - synchronizer depth, must be 2 or more
// Ports       : clk   in  system clock
//               rst   in  asynchronous active-high reset
//               d     in  asynchronous input
//               level out synchronized level
//               rise  out one-cycle strobe, synchronized 0->1
//               fall  out one-cycle strobe, synchronized 1->0
// ============================================================================
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  // sync_q[0] is the first (metastability-catching) stage.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule : sync_edge_detect
`default_nettype wire

// File: rtl/clk_period_meter.sv
`default_nettype none
// ============================================================================
// Module      : clk_period_meter
// Description : Measures the period (rise to rise) and high time (rise to
//               fall) of a slow asynchronous square wave in clk cycles and
//               flags the input as stalled when no rising edge arrives within
//               TIMEOUT cycles.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters  : CNT_WIDTH   - width of counter and all measurement outputs
//               SYNC_STAGES - synchronizer depth on sig_in (>= 2)
//               TIMEOUT     - cycles after last rise before stall, 2..2^W-1
// Ports       : clk        in  system clock
//               rst        in  asynchronous active-high reset
//               sig_in     in  asynchronous signal to measure
//               sig_rise   out one-cycle pulse per detected rising edge
//               period_out out last measured period
//               high_out   out high time belonging to period_out
//               meas_valid out one-cycle pulse when period/high update
//               stalled    out level, no rise within TIMEOUT cycles
// Option      : `define CLK_METER_MINMAX_EN adds period_min / period_max
//               (running extremes, cleared when the input stalls).
// ============================================================================
module clk_period_meter
  import clk_period_meter_pkg::*;
#(
  parameter int CNT_WIDTH   = c_default_cnt_width,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = c_default_timeout
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sig_in,
  output logic                 sig_rise,
  output logic [CNT_WIDTH-1:0] period_out,
  output logic [CNT_WIDTH-1:0] high_out,
  output logic                 meas_valid,
  output logic                 stalled
`ifdef CLK_METER_MINMAX_EN
  ,
  output logic [CNT_WIDTH-1:0] period_min,
  output logic [CNT_WIDTH-1:0] period_max
`endif
);

  localparam logic [CNT_WIDTH-1:0] c_timeout = CNT_WIDTH'(TIMEOUT);

  meter_state_e         state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] high_cap_q, high_cap_d;
  logic [CNT_WIDTH-1:0] period_q, period_d;
  logic [CNT_WIDTH-1:0] high_q, high_d;
  logic                 meas_valid_q, meas_valid_d;
  logic                 stalled_q, stalled_d;
  logic                 sig_rise_q;

  logic w_level;
  logic w_rise;
  logic w_fall;
  logic w_timeout;
  logic w_unused;

  sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst   (rst),
    .d     (sig_in),
    .level (w_level),
    .rise  (w_rise),
    .fall  (w_fall)
  );

  // Only the edge strobes drive the meter.
  assign w_unused = w_level;

  // A rise in the same cycle as the limit completes the measurement instead.
  assign w_timeout = (cnt_q == c_timeout) && !w_rise;

  always_comb begin
    state_d      = state_q;
    high_cap_d   = high_cap_q;
    period_d     = period_q;
    high_d       = high_q;
    meas_valid_d = 1'b0;
    stalled_d    = stalled_q;

    // The counter restarts at 1 on every rise so that a rise every P cycles
    // reads back exactly P at the next rise.
    if (w_rise) begin
      cnt_d = CNT_WIDTH'(1);
    end else if (state_q != IDLE && !w_timeout) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end else begin
      cnt_d = '0;
    end

    case (state_q)
      IDLE: begin
        // First edge only arms the meter; no measurement is reported.
        if (w_rise) begin
          state_d   = MEAS_HIGH;
          stalled_d = 1'b0;
        end
      end
      MEAS_HIGH: begin
        if (w_timeout) begin
          state_d   = IDLE;
          stalled_d = 1'b1;
        end else if (w_fall) begin
          high_cap_d = cnt_q;
          state_d    = MEAS_LOW;
        end
      end
      MEAS_LOW: begin
        if (w_rise) begin
          period_d     = cnt_q;
          high_d       = high_cap_q;
          meas_valid_d = 1'b1;
          state_d      = MEAS_HIGH;
        end else if (w_timeout) begin
          state_d   = IDLE;
          stalled_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      high_cap_q   <= '0;
      period_q     <= '0;
      high_q       <= '0;
      meas_valid_q <= 1'b0;
      stalled_q    <= 1'b0;
      sig_rise_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      high_cap_q   <= high_cap_d;
      period_q     <= period_d;
      high_q       <= high_d;
      meas_valid_q <= meas_valid_d;
      stalled_q    <= stalled_d;
      sig_rise_q   <= w_rise;
    end
  end

  assign sig_rise   = sig_rise_q;
  assign period_out = period_q;
  assign high_out   = high_q;
  assign meas_valid = meas_valid_q;
  assign stalled    = stalled_q;

`ifdef CLK_METER_MINMAX_EN
  logic [CNT_WIDTH-1:0] min_q, min_d;
  logic [CNT_WIDTH-1:0] max_q, max_d;

  // Extremes track every completed period and restart whenever the input
  // is declared stalled (the timeout path is the only way stalled_d rises).
  always_comb begin
    min_d = min_q;
    max_d = max_q;
    if (meas_valid_d) begin
      if (period_d < min_q) min_d = period_d;
      if (period_d > max_q) max_d = period_d;
    end else if (stalled_d && !stalled_q) begin
      min_d = '1;
      max_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min_q <= '1;
      max_q <= '0;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
    end
  end

  assign period_min = min_q;
  assign period_max = max_q;
`endif

endmodule : clk_period_meter
`default_nettype wire

// File: tb/tb_clk_period_meter.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_period_meter
// Description : Self-checking bench for clk_period_meter. Two instances
//               (TIMEOUT 100 and 20) are exercised one at a time through a
//               shared monitor; expected measurements are queued when each
//               rising edge is driven and compared when meas_valid pulses.
//               `define CLK_METER_MINMAX_EN also checks period_min/max.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_period_meter;

  localparam int W     = 16;
  localparam int TMO_A = 100;
  localparam int TMO_B = 20;

  typedef struct {
    int dut;
    int hi;
    int lo;
    int reps;
    int exp_valids;
    int exp_period;
    int exp_high;
    int exp_stall_ev;
  } vec_t;

  typedef struct {
    int per;
    int hi;
  } exp_t;

  logic         clk, rst, sig_a, sig_b;
  logic         rise_a, rise_b, mv_a, mv_b, st_a, st_b;
  logic [W-1:0] per_a, per_b, hi_a, hi_b;
`ifdef CLK_METER_MINMAX_EN
  logic [W-1:0] pmin_a, pmax_a, pmin_b, pmax_b;
`endif

  bit           sel;
  logic         w_rise, w_mv, w_stalled;
  logic [W-1:0] w_period, w_high;

  assign w_rise    = sel ? rise_b : rise_a;
  assign w_mv      = sel ? mv_b   : mv_a;
  assign w_stalled = sel ? st_b   : st_a;
  assign w_period  = sel ? per_b  : per_a;
  assign w_high    = sel ? hi_b   : hi_a;

  clk_period_meter #(.CNT_WIDTH(W), .SYNC_STAGES(2), .TIMEOUT(TMO_A)) u_dut_a (
    .clk        (clk),
    .rst        (rst),
    .sig_in     (sig_a),
    .sig_rise   (rise_a),
    .period_out (per_a),
    .high_out   (hi_a),
    .meas_valid (mv_a),
    .stalled    (st_a)
`ifdef CLK_METER_MINMAX_EN
    ,
    .period_min (pmin_a),
    .period_max (pmax_a)
`endif
  );

  clk_period_meter #(.CNT_WIDTH(W), .SYNC_STAGES(2), .TIMEOUT(TMO_B)) u_dut_b (
    .clk        (clk),
    .rst        (rst),
    .sig_in     (sig_b),
    .sig_rise   (rise_b),
    .period_out (per_b),
    .high_out   (hi_b),
    .meas_valid (mv_b),
    .stalled    (st_b)
`ifdef CLK_METER_MINMAX_EN
    ,
    .period_min (pmin_b),
    .period_max (pmax_b)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   last_rise_cyc = 0;
  int   n_rise = 0, n_valid = 0, n_stall_ev = 0;
  bit   prev_sr = 1'b0, prev_mv = 1'b0, prev_st = 1'b0;
  exp_t exp_q[$];
  int   m_per = 0, m_hi = 0;
  bit   m_armed = 1'b0;
  int   last_per[2];
  int   last_hi[2];
  int   v0, r0, e0;
  vec_t vecs[7];

  task automatic chk_eq(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: actual %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Main-thread step: lands 2 time units after the falling edge so the
  // monitor (which runs on the falling edge) has always finished first.
  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic set_sig(input bit v);
    if (sel) sig_b = v;
    else     sig_a = v;
  endtask

  // One period of the input. The rise closes the previous period, so that
  // period's expectation is queued here if the model considers the meter armed.
  task automatic drive_period(input int hi, input int lo, input int per,
                              input int hv, input bit meas);
    if (m_armed) exp_q.push_back('{per: m_per, hi: m_hi});
    m_armed = meas;
    m_per   = per;
    m_hi    = hv;
    set_sig(1'b1);
    repeat (hi) tick();
    set_sig(1'b0);
    repeat (lo) tick();
  endtask

  task automatic wait_stall(input int tmo);
    int n;
    n = 0;
    while (!w_stalled && n < tmo + 40) begin
      tick();
      n++;
    end
    chk_eq("stall_seen", w_stalled, 1);
    chk_eq("stall_latency", cyc - last_rise_cyc, tmo);
    m_armed = 1'b0;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Monitor / scoreboard consumer.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (w_rise) begin
          n_rise++;
          last_rise_cyc = cyc;
          chk_eq("sig_rise_width", prev_sr, 0);
        end
        if (w_stalled && !prev_st) n_stall_ev++;
        if (w_mv) begin
          n_valid++;
          chk_eq("meas_valid_width", prev_mv, 0);
          chk_eq("scoreboard_nonempty", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk_eq("period_out", w_period, e.per);
            chk_eq("high_out", w_high, e.hi);
          end
        end
      end
      prev_sr = w_rise;
      prev_mv = w_mv;
      prev_st = w_stalled;
    end
  end

  initial begin
    //        dut hi  lo reps valids period high stall_events
    vecs[0] = '{0,  2,  2, 8, 7,   4,   2, 0};   // divide-by-4 waveform
    vecs[1] = '{0,  3,  7, 5, 4,  10,   3, 0};   // 3 high / 7 low
    vecs[2] = '{0,  1,  5, 4, 3,   6,   1, 0};   // single-cycle high
    vecs[3] = '{0, 50, 49, 3, 2,  99,  50, 0};   // just under timeout
    vecs[4] = '{0, 60, 40, 3, 2, 100,  60, 0};   // period == timeout
    vecs[5] = '{1, 10, 10, 4, 3,  20,  10, 0};   // period == timeout (20)
    vecs[6] = '{1, 10, 11, 3, 0,   0,   0, 2};   // period > timeout: stalls
    last_per[0] = 0; last_per[1] = 0;
    last_hi[0]  = 0; last_hi[1]  = 0;

    rst = 1'b1; sig_a = 1'b0; sig_b = 1'b0; sel = 1'b0;
    repeat (3) tick();
    chk_eq("rst_period_a", per_a, 0);
    chk_eq("rst_high_a", hi_a, 0);
    chk_eq("rst_valid_a", mv_a, 0);
    chk_eq("rst_rise_a", rise_a, 0);
    chk_eq("rst_stalled_a", st_a, 0);
    chk_eq("rst_period_b", per_b, 0);
`ifdef CLK_METER_MINMAX_EN
    chk_eq("rst_min_a", pmin_a, 16'hFFFF);
    chk_eq("rst_max_a", pmax_a, 0);
    chk_eq("rst_min_b", pmin_b, 16'hFFFF);
    chk_eq("rst_max_b", pmax_b, 0);
`endif
    rst = 1'b0;
    repeat (2) tick();
    chk_eq("idle_stalled_a", st_a, 0);
    chk_eq("idle_valid_a", mv_a, 0);

    for (int i = 0; i < 7; i++) begin
      sel = (vecs[i].dut == 1);
      tick();
      v0 = n_valid; r0 = n_rise; e0 = n_stall_ev;
      for (int r = 0; r < vecs[i].reps; r++) begin
        drive_period(vecs[i].hi, vecs[i].lo, vecs[i].exp_period,
                     vecs[i].exp_high, vecs[i].exp_valids > 0);
        if (r == 0 && vecs[i].exp_stall_ev == 0)
          chk_eq("stalled_cleared", w_stalled, 0);
      end
      chk_eq("stall_events", n_stall_ev - e0, vecs[i].exp_stall_ev);
      wait_stall(vecs[i].dut == 1 ? TMO_B : TMO_A);
      if (vecs[i].exp_valids > 0) begin
        last_per[vecs[i].dut] = vecs[i].exp_period;
        last_hi[vecs[i].dut]  = vecs[i].exp_high;
      end
      chk_eq("valid_count", n_valid - v0, vecs[i].exp_valids);
      chk_eq("rise_count", n_rise - r0, vecs[i].reps);
      chk_eq("queue_drained", exp_q.size(), 0);
      chk_eq("period_hold", w_period, last_per[vecs[i].dut]);
      chk_eq("high_hold", w_high, last_hi[vecs[i].dut]);
    end

    // Reset in the middle of MEAS_LOW with sig_in high across release.
    sel = 1'b0;
    tick();
    drive_period(3, 7, 10, 3, 1'b1);
    drive_period(3, 7, 10, 3, 1'b1);
    if (m_armed) exp_q.push_back('{per: m_per, hi: m_hi});
    m_armed = 1'b0;
    sig_a = 1'b1;
    repeat (3) tick();
    sig_a = 1'b0;
    repeat (4) tick();
    chk_eq("pre_rst_period", per_a, 10);
    chk_eq("pre_rst_queue", exp_q.size(), 0);
    rst = 1'b1;
    sig_a = 1'b1;
    #1;
    chk_eq("async_rst_period", per_a, 0);
    chk_eq("async_rst_high", hi_a, 0);
    chk_eq("async_rst_valid", mv_a, 0);
    chk_eq("async_rst_rise", rise_a, 0);
    chk_eq("async_rst_stalled", st_a, 0);
    repeat (3) tick();
    rst = 1'b0;
    v0 = n_valid; r0 = n_rise;
    m_armed = 1'b1; m_per = 10; m_hi = 3;
    repeat (3) tick();
    sig_a = 1'b0;
    repeat (7) tick();
    drive_period(3, 7, 10, 3, 1'b1);
    drive_period(3, 7, 10, 3, 1'b1);
    wait_stall(TMO_A);
    chk_eq("post_rst_valids", n_valid - v0, 2);
    chk_eq("post_rst_rises", n_rise - r0, 3);
    chk_eq("post_rst_queue", exp_q.size(), 0);
    chk_eq("post_rst_period", per_a, 10);
    chk_eq("post_rst_high", hi_a, 3);

`ifdef CLK_METER_MINMAX_EN
    tick();
    drive_period(4, 4, 8, 4, 1'b1);
    drive_period(6, 6, 12, 6, 1'b1);
    drive_period(3, 3, 6, 3, 1'b1);
    drive_period(2, 2, 4, 2, 1'b1);
    chk_eq("period_min", pmin_a, 6);
    chk_eq("period_max", pmax_a, 12);
    wait_stall(TMO_A);
    chk_eq("stall_min", pmin_a, 16'hFFFF);
    chk_eq("stall_max", pmax_a, 0);
    chk_eq("minmax_queue", exp_q.size(), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_clk_period_meter
`default_nettype wire
